// File: rtl/mem_access_ctrl.sv
// MEM-stage access sequencer: steers VLD/VSD to single-cycle DMEM or to the
// multi-cycle NIC register window (req/ack handshake with optional timeout).
module mem_access_ctrl #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [1:0]  NIC_BASE = 2'b11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_memEn,
  input  logic              req_memwrEn,
  input  logic [0:ADDR_W-1] req_addr,
  input  logic [0:DATA_W-1] req_wdata,
  input  logic [0:4]        req_rD,
  output logic              stall,
  output logic              dmem_en,
  output logic              dmem_wrEn,
  output logic [0:7]        dmem_addr,
  output logic [0:DATA_W-1] dmem_din,
  input  logic [0:DATA_W-1] dmem_dout,
  output logic              nic_en,
  output logic              nic_wrEn,
  output logic [0:1]        nic_addr,
  output logic [0:DATA_W-1] nic_din,
  input  logic [0:DATA_W-1] nic_dout,
  input  logic              nic_ack,
  input  logic              err_clr,
  output logic [0:DATA_W-1] rdata,
  output logic              rdata_valid,
  output logic [0:4]        rd_tag,
  output logic              err_timeout
);

  localparam int unsigned CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 7) ? 7 : CNT_RAW;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    NIC_REQ  = 2'd1,
    NIC_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [0:4]         nic_tag;
  logic [0:DATA_W-1]  rdata_q;
  logic               dmem_pend;

  logic is_nic;
  logic dmem_go;
  logic nic_go;
  logic timeout_hit;
  logic unused_addr_bits;

  // Address decode and request qualification (requests only accepted in IDLE)
  assign is_nic      = (req_addr[0:1] == NIC_BASE);
  assign dmem_go     = (state == IDLE) && req_memEn && !is_nic;
  assign nic_go      = (state == IDLE) && req_memEn && is_nic;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
  assign unused_addr_bits = ^req_addr[2:ADDR_W-9];

  // Same-cycle DMEM drive and pipeline stall
  assign stall     = nic_go || (state == NIC_REQ);
  assign dmem_en   = dmem_go;
  assign dmem_wrEn = dmem_go && req_memwrEn;
  assign dmem_addr = dmem_go ? req_addr[ADDR_W-8:ADDR_W-1] : 8'd0;
  assign dmem_din  = dmem_go ? req_wdata : '0;

  // DMEM read data arrives one cycle after enable, so it bypasses the result register
  assign rdata = dmem_pend ? dmem_dout : rdata_q;

  // Access sequencer, NIC handshake, timeout counter and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      nic_en      <= 1'b0;
      nic_wrEn    <= 1'b0;
      nic_addr    <= 2'd0;
      nic_din     <= '0;
      nic_tag     <= 5'd0;
      rdata_q     <= '0;
      rdata_valid <= 1'b0;
      rd_tag      <= 5'd0;
      err_timeout <= 1'b0;
      dmem_pend   <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      dmem_pend   <= 1'b0;
      if (err_clr) err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (dmem_go && !req_memwrEn) begin
            rdata_valid <= 1'b1;
            dmem_pend   <= 1'b1;
            rd_tag      <= req_rD;
          end else if (nic_go) begin
            state    <= NIC_REQ;
            nic_en   <= 1'b1;
            nic_wrEn <= req_memwrEn;
            nic_addr <= req_addr[ADDR_W-2:ADDR_W-1];
            nic_din  <= req_wdata;
            nic_tag  <= req_rD;
            cnt      <= '0;
          end
        end
        NIC_REQ: begin
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
          if (nic_ack) begin
            nic_en <= 1'b0;
            state  <= NIC_DONE;
            if (!nic_wrEn) begin
              rdata_q     <= nic_dout;
              rdata_valid <= 1'b1;
              rd_tag      <= nic_tag;
            end
          end else if (timeout_hit) begin
            nic_en      <= 1'b0;
            state       <= NIC_DONE;
            err_timeout <= 1'b1;
            if (!nic_wrEn) begin
              rdata_q     <= '0;
              rdata_valid <= 1'b1;
              rd_tag      <= nic_tag;
            end
          end
        end
        NIC_DONE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
